// File: rtl/pipe_stage_chain.sv
// Elastic pipeline register: STAGES chained stages, each a main register plus a skid
// entry, so in_ready comes straight from a flop. Supports flush and occupancy counting.
module pipe_stage_chain #(
  parameter int                 WIDTH  = 32,
  parameter int                 STAGES = 1,
  parameter logic [WIDTH-1:0]   BUBBLE = '0,
  parameter int                 OCC_W  = $clog2(2*STAGES+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  // state | meaning
  // EMPTY | no entries; main and skid hold BUBBLE
  // ONE   | main holds the head entry, skid empty
  // TWO   | main holds the head, skid the next; input stalled
  typedef enum logic [1:0] {EMPTY, ONE, TWO} stage_state_t;

  // Index k is the handshake into stage k; index STAGES is the chain output.
  logic [STAGES:0]            vld;
  logic [STAGES:0]            rdy;
  logic [STAGES:0][WIDTH-1:0] dat;

  assign vld[0]      = in_valid;
  assign dat[0]      = in_data;
  assign in_ready    = rdy[0];
  assign out_valid   = vld[STAGES];
  assign out_data    = dat[STAGES];
  assign rdy[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_state_t     state, state_n;
    logic [WIDTH-1:0] main_q, main_n;
    logic [WIDTH-1:0] skid_q, skid_n;
    logic             rdy_q;
    logic             acc, emt;

    assign acc        = vld[k] & rdy_q;
    assign emt        = (state != EMPTY) & rdy[k+1];
    assign rdy[k]     = rdy_q;
    assign vld[k+1]   = (state != EMPTY);
    assign dat[k+1]   = main_q;

    always_comb begin
      state_n = state;
      main_n  = main_q;
      skid_n  = skid_q;
      case (state)
        EMPTY: begin
          if (acc) begin
            state_n = ONE;
            main_n  = dat[k];
          end
        end
        ONE: begin
          if (acc && !emt) begin
            state_n = TWO;
            skid_n  = dat[k];
          end else if (emt && !acc) begin
            state_n = EMPTY;
            main_n  = BUBBLE;
          end else if (acc && emt) begin
            main_n  = dat[k];
          end
        end
        TWO: begin
          if (emt) begin
            state_n = ONE;
            main_n  = skid_q;
            skid_n  = BUBBLE;
          end
        end
        default: begin
          state_n = EMPTY;
          main_n  = BUBBLE;
          skid_n  = BUBBLE;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset || flush) begin
        state  <= EMPTY;
        main_q <= BUBBLE;
        skid_q <= BUBBLE;
        rdy_q  <= 1'b1;
      end else begin
        state  <= state_n;
        main_q <= main_n;
        skid_q <= skid_n;
        rdy_q  <= (state_n != TWO);
      end
    end
  end

  logic acc_top, emt_top;
  assign acc_top = in_valid & in_ready;
  assign emt_top = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCC_W'(acc_top) - OCC_W'(emt_top);
    end
  end

endmodule

// File: doc/pipe_stage_chain.md
Name: pipe_stage_chain

Overview:
Parametrised elastic pipeline register that generalises the fixed stage-boundary structs (if_id_t, id_ex_t, ex_mem_t, mem_wb_t) into one reusable block. It carries an opaque WIDTH-bit payload through STAGES register stages. The block adds a valid/ready handshake, a per-stage skid entry so in_ready is fully registered, flush with bubble insertion, and an occupancy count. Each core stage boundary instantiates it, with the payload being the packed struct for that boundary.

Parameters:
WIDTH, 32, payload width in bits (set to $bits of the boundary struct); must be >= 1.
STAGES, 1, number of chained register stages; must be >= 1.
BUBBLE, '0, payload value driven while the output is invalid and loaded on flush/reset (the NOP encoding for the boundary).
OCC_W, $clog2(2*STAGES+1), occupancy counter width (derived).

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
flush  in  1  discard all contents at next edge (branch/jump redirect)
in_valid  in  1  upstream payload valid
in_ready  out  1  block accepts payload this cycle; registered
in_data  in  WIDTH  upstream payload
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts this cycle
out_data  out  WIDTH  payload from last stage; BUBBLE when out_valid=0
occupancy  out  OCC_W  total entries held across all stages, 0..2*STAGES

Behaviour:
- Reset and flush are both synchronous, one clock. Next-cycle state: all stages EMPTY, main/skid regs = BUBBLE, in_ready=1, out_valid=0, out_data=BUBBLE, occupancy=0. Reset has priority over flush. Flush has priority over any accept/emit in the same cycle; the beat presented that cycle is dropped.
- Transfer rules:
  - Accept = in_valid & in_ready; emit = out_valid & out_ready.
  - Stage k's output handshake is stage k+1's input handshake.
  - in_valid/in_data must not depend on in_ready combinationally.
- Per-stage FSM, holding main and skid registers:
  - EMPTY: accept -> ONE, main<=data.
  - ONE: accept&!emit -> TWO, skid<=data. emit&!accept -> EMPTY, main<=BUBBLE. accept&emit -> ONE, main<=data.
  - TWO: emit -> ONE, main<=skid, skid<=BUBBLE. No accept in TWO.
- Per-stage outputs:
  - stage in_ready = register, next value = (next_state != TWO).
  - stage out_valid = (state != EMPTY).
  - stage out_data = main.
- Latency and throughput:
  - A beat accepted at edge N with out_ready held high is visible on out_data after edge N+STAGES-1, i.e. STAGES cycles of register delay.
  - Sustained throughput is 1 beat/cycle with no bubbles while out_ready=1.
- Ordering and capacity:
  - Strict FIFO order; no loss or duplication under any out_ready pattern.
  - Capacity = 2*STAGES beats. in_ready deasserts the cycle after the chain holds 2*STAGES entries with no emit.
- Occupancy:
  - occupancy_next = occupancy + accept - emit, with accept and emit taken at the chain ends.
  - Accept and emit in the same cycle leaves it unchanged.
  - Never exceeds 2*STAGES and never wraps.
- While out_valid=0, out_data must equal BUBBLE exactly. While out_valid=1, out_data is stable until emit.
- Assertions (bench):
  - out_data stable while out_valid & !out_ready.
  - occupancy equals the sum of stage counts.
  - in_ready=0 whenever occupancy==2*STAGES.

Test Plan:
1. Reset: STAGES=2, WIDTH=8, BUBBLE=8'h13; assert reset 2 cycles mid-traffic -> next cycle out_valid=0, out_data=8'h13, in_ready=1, occupancy=0.
2. Streaming: STAGES=2, out_ready=1, send 8'h01..8'h08 back-to-back -> outputs 01..08 in order on consecutive cycles; first appears 2 cycles after accept; in_ready never drops.
3. Backpressure: STAGES=2, out_ready=0, in_valid=1 with 8'hA0,A1,...
   - Exactly 4 beats accepted, then in_ready=0 and occupancy=4.
   - Raise out_ready -> A0..A3 emerge in order with no loss, and in_ready returns.
4. Flush: STAGES=2, occupancy=3, flush=1 with in_valid=1 (8'hFF) -> next cycle occupancy=0, out_valid=0, out_data=8'h13; 8'hFF never appears at the output.
5. Simultaneous accept/emit: STAGES=1, stage in ONE holding 8'h10; in 8'h11 with out_ready=1 -> 10 emitted, state ONE, main=11, occupancy stays 1.
6. Random stall: 1000 beats, random in_valid/out_ready at 50% -> scoreboard matches exactly, and all assertions hold.
